// File: rtl/strassen_pkg.sv
// strassen_pkg: definitions shared by the Strassen 2x2 loader and compute stages.
//   - ALU op codes used by the compute FSM
//   - loader FSM state encoding
//   - operand slot indices (A11..A22 = 0..3, B11..B22 = 4..7)
//   - default element and address widths
package strassen_pkg;

    localparam int DATA_W_DEFAULT = 16;
    localparam int ADDR_W_DEFAULT = 8;
    localparam int NUM_SLOTS      = 8;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'd0,
        ALU_SUB  = 2'd1,
        ALU_MULT = 2'd2
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DRAIN   = 2'd2,
        PRESENT = 2'd3
    } loader_state_e;

    localparam logic [2:0] A11 = 3'd0;
    localparam logic [2:0] A12 = 3'd1;
    localparam logic [2:0] A21 = 3'd2;
    localparam logic [2:0] A22 = 3'd3;
    localparam logic [2:0] B11 = 3'd4;
    localparam logic [2:0] B12 = 3'd5;
    localparam logic [2:0] B21 = 3'd6;
    localparam logic [2:0] B22 = 3'd7;

endpackage

// File: rtl/strassen_operand_regs.sv
// strassen_operand_regs: 8-entry operand slot file for the Strassen loader.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (clears every slot)
//   we_i         write enable
//   widx_i       slot index to write (A11..B22)
//   wdata_i      element written into slot widx_i
//   op_a_o       {a22,a21,a12,a11}, a11 in the LSBs
//   op_b_o       {b22,b21,b12,b11}, b11 in the LSBs
module strassen_operand_regs
    import strassen_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we_i,
    input  logic [2:0]          widx_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [4*DATA_W-1:0] op_a_o,
    output logic [4*DATA_W-1:0] op_b_o
);

    logic [DATA_W-1:0] slot_q [NUM_SLOTS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the operands must read as zero straight out of reset, so
            // the slot file is built from resettable flops, not a RAM macro.
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= '0;
            end
        end else if (we_i) begin
            slot_q[widx_i] <= wdata_i;
        end
    end

    assign op_a_o = {slot_q[A22], slot_q[A21], slot_q[A12], slot_q[A11]};
    assign op_b_o = {slot_q[B22], slot_q[B21], slot_q[B12], slot_q[B11]};

endmodule

// File: rtl/strassen_operand_loader.sv
// strassen_operand_loader: fetches one 2x2 operand pair (A then B, 8 words)
// from a synchronous-read memory and presents it to the compute stage with a
// valid/ready handshake.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              load request, accepted in IDLE or on a PRESENT handshake
//   base_a, base_b     addresses of a11 / b11 (next elements at +1..+3, wrapping)
//   mem_re, mem_addr   operand memory read port
//   mem_rdata          read data, valid one cycle after mem_re
//   op_a, op_b         held operand pair
//   ops_valid          op_a/op_b hold a freshly loaded pair
//   ops_ready          compute stage consumes the pair
//   busy               loader not in IDLE
//   load_count         completed loads, saturating; only counts when the
//                      macro STRASSEN_LOADER_PERF_EN is defined, otherwise 0
module strassen_operand_loader
    import strassen_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_a,
    input  logic [ADDR_W-1:0]   base_b,
    output logic                mem_re,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [4*DATA_W-1:0] op_a,
    output logic [4*DATA_W-1:0] op_b,
    output logic                ops_valid,
    input  logic                ops_ready,
    output logic                busy,
    output logic [15:0]         load_count
);

    loader_state_e     state_q, state_d;
    logic [2:0]        k_q, k_d;
    logic [ADDR_W-1:0] base_a_q, base_a_d;
    logic [ADDR_W-1:0] base_b_q, base_b_d;
    logic              ops_valid_q, ops_valid_d;
    logic              cap_en_q;
    logic [2:0]        cap_idx_q;
    logic              accept;
    logic              handshake;
    logic [ADDR_W-1:0] offset;

    assign handshake = (state_q == PRESENT) && ops_valid_q && ops_ready;
    // Issues 0..3 walk the A block, 4..7 the B block; the sum wraps naturally.
    assign offset    = {{(ADDR_W-2){1'b0}}, k_q[1:0]};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves a signal unassigned and infers a latch.
        state_d     = state_q;
        k_d         = k_q;
        base_a_d    = base_a_q;
        base_b_d    = base_b_q;
        ops_valid_d = ops_valid_q;
        accept      = 1'b0;
        mem_re      = 1'b0;
        mem_addr    = '0;

        case (state_q)
            IDLE: accept = start;
            FETCH: begin
                mem_re   = 1'b1;
                mem_addr = k_q[2] ? (base_b_q + offset) : (base_a_q + offset);
                k_d      = k_q + 3'd1;
                if (k_q == 3'd7) state_d = DRAIN;
            end
            DRAIN: state_d = PRESENT;
            PRESENT: begin
                // The first PRESENT cycle only raises valid: slot 7 was
                // written on the edge that entered this state.
                if (!ops_valid_q) begin
                    ops_valid_d = 1'b1;
                end else if (ops_ready) begin
                    ops_valid_d = 1'b0;
                    if (start) accept  = 1'b1;
                    else       state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d  = FETCH;
            k_d      = '0;
            base_a_d = base_a;
            base_b_d = base_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            base_a_q    <= '0;
            base_b_q    <= '0;
            ops_valid_q <= 1'b0;
            cap_en_q    <= 1'b0;
            cap_idx_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            k_q         <= k_d;
            base_a_q    <= base_a_d;
            base_b_q    <= base_b_d;
            ops_valid_q <= ops_valid_d;
            // Read data returns one cycle after issue; remember where it goes.
            cap_en_q    <= mem_re;
            cap_idx_q   <= k_q;
        end
    end

    strassen_operand_regs #(
        .DATA_W (DATA_W)
    ) u_regs (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (cap_en_q),
        .widx_i  (cap_idx_q),
        .wdata_i (mem_rdata),
        .op_a_o  (op_a),
        .op_b_o  (op_b)
    );

    assign ops_valid = ops_valid_q;
    assign busy      = (state_q != IDLE);

`ifdef STRASSEN_LOADER_PERF_EN
    logic [15:0] load_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_count_q <= '0;
        end else if (handshake && (load_count_q != 16'hFFFF)) begin
            load_count_q <= load_count_q + 16'd1;
        end
    end

    assign load_count = load_count_q;
`else
    assign load_count = 16'd0;
`endif

endmodule

// File: tb/tb_strassen_operand_loader.sv
// Self-checking bench for strassen_operand_loader: table-driven loads plus
// hand-written back-to-back, ignored-start and reset-mid-fetch sequences.
// Issued addresses and operand pairs are checked against scoreboard queues
// filled when each start is driven.
module tb_strassen_operand_loader;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
`ifdef STRASSEN_LOADER_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                start = 1'b0;
    logic [ADDR_W-1:0]   base_a = '0;
    logic [ADDR_W-1:0]   base_b = '0;
    logic                mem_re;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_rdata = '0;
    logic [4*DATA_W-1:0] op_a, op_b;
    logic                ops_valid;
    logic                ops_ready = 1'b0;
    logic                busy;
    logic [15:0]         load_count;

    strassen_operand_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_a     (base_a),
        .base_b     (base_b),
        .mem_re     (mem_re),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .op_a       (op_a),
        .op_b       (op_b),
        .ops_valid  (ops_valid),
        .ops_ready  (ops_ready),
        .busy       (busy),
        .load_count (load_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int reads_seen = 0;
    int hs_count = 0;

    logic [DATA_W-1:0] mem [256];
    logic [7:0]        exp_addr_q [$];
    logic [127:0]      sb_q [$];

    typedef struct {
        logic [7:0]  ba;
        logic [7:0]  bb;
        logic        ready_early;
        logic [63:0] exp_a;
        logic [63:0] exp_b;
    } vec_t;

    localparam int NV = 4;
    vec_t vec [NV];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pair(input logic [7:0] b);
        return {mem[8'(b + 3)], mem[8'(b + 2)], mem[8'(b + 1)], mem[b]};
    endfunction

    // Synchronous-read operand memory.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    // Every issued read must match the next expected address.
    always @(negedge clk) begin
        if (rst_n && mem_re) begin
            reads_seen++;
            if (exp_addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_read: addr %0h issued, none expected", mem_addr);
            end else begin
                check("mem_addr", mem_addr, exp_addr_q.pop_front());
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) hs_count <= 0;
        else if (ops_valid && ops_ready) hs_count <= hs_count + 1;
    end

    // Drive a start request and push the expectations it implies.
    task automatic issue(input logic [7:0] ba, input logic [7:0] bb,
                         input logic [63:0] ea, input logic [63:0] eb);
        start  = 1'b1;
        base_a = ba;
        base_b = bb;
        for (int i = 0; i < 4; i++) exp_addr_q.push_back(8'(ba + i));
        for (int i = 0; i < 4; i++) exp_addr_q.push_back(8'(bb + i));
        sb_q.push_back({eb, ea});
    endtask

    // Count edges until ops_valid is seen; bounded.
    task automatic wait_valid(input string name, input int exp_edges);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!ops_valid && n < 20);
        check(name, n, exp_edges);
    endtask

    task automatic check_pair(input string name, output logic [63:0] ea, output logic [63:0] eb);
        logic [127:0] e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: pair presented, none expected", name);
            ea = '0;
            eb = '0;
        end else begin
            e  = sb_q.pop_front();
            ea = e[63:0];
            eb = e[127:64];
            check({name, "_op_a"}, op_a, ea);
            check({name, "_op_b"}, op_b, eb);
        end
    endtask

    task automatic handshake_to_idle(input string name);
        ops_ready = 1'b1;
        @(posedge clk);
        #1;
        ops_ready = 1'b0;
        check({name, "_valid_drop"}, ops_valid, 1'b0);
        check({name, "_idle"}, busy, 1'b0);
        check({name, "_load_count"}, load_count, PERF_EN ? 16'(hs_count) : 16'd0);
    endtask

    task automatic run_vec(input int v);
        int r0;
        logic [63:0] ea, eb;
        @(posedge clk);
        #1;
        r0 = reads_seen;
        issue(vec[v].ba, vec[v].bb, vec[v].exp_a, vec[v].exp_b);
        ops_ready = vec[v].ready_early;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("vec_busy", busy, 1'b1);
        check("vec_valid_low", ops_valid, 1'b0);
        wait_valid("vec_latency", 10);
        check_pair("vec", ea, eb);
        if (!vec[v].ready_early) begin
            repeat (3) @(posedge clk);
            #1;
            check("vec_hold_valid", ops_valid, 1'b1);
            check("vec_hold_op_a", op_a, ea);
            check("vec_hold_op_b", op_b, eb);
        end
        handshake_to_idle("vec");
        check("vec_reads", reads_seen - r0, 8);
    endtask

    initial begin
        logic [63:0] ea, eb;
        int r0;

        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 257) ^ 16'h5A00;
        for (int i = 0; i < 4; i++) begin
            mem[8'h10 + i] = 16'(i + 1);
            mem[8'h20 + i] = 16'(i + 5);
        end

        vec[0] = '{8'h10, 8'h20, 1'b0, 64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005};
        vec[1] = '{8'hFE, 8'hFF, 1'b0, pair(8'hFE), pair(8'hFF)};
        vec[2] = '{8'h30, 8'h32, 1'b1, pair(8'h30), pair(8'h32)};
        vec[3] = '{8'h80, 8'h04, 1'b1, pair(8'h80), pair(8'h04)};

        #1 rst_n = 1'b0;
        #11;
        check("rst_mem_re", mem_re, 1'b0);
        check("rst_mem_addr", mem_addr, 8'h00);
        check("rst_op_a", op_a, 64'h0);
        check("rst_op_b", op_b, 64'h0);
        check("rst_ops_valid", ops_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_load_count", load_count, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < NV; v++) run_vec(v);

        // Back-to-back: handshake and new start in the same cycle.
        @(posedge clk);
        #1;
        r0 = reads_seen;
        issue(8'h40, 8'h48, pair(8'h40), pair(8'h48));
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_valid("b2b_first_latency", 10);
        check_pair("b2b_first", ea, eb);
        ops_ready = 1'b1;
        issue(8'h50, 8'h58, pair(8'h50), pair(8'h58));
        @(posedge clk);
        #1;
        start = 1'b0;
        ops_ready = 1'b0;
        check("b2b_valid_drop", ops_valid, 1'b0);
        check("b2b_busy", busy, 1'b1);
        check("b2b_mem_re", mem_re, 1'b1);
        wait_valid("b2b_second_latency", 10);
        check_pair("b2b_second", ea, eb);
        handshake_to_idle("b2b");
        check("b2b_reads", reads_seen - r0, 16);

        // Start pulsed during FETCH (k=3) is ignored.
        @(posedge clk);
        #1;
        r0 = reads_seen;
        issue(8'h60, 8'h68, pair(8'h60), pair(8'h68));
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start  = 1'b1;
        base_a = 8'h70;
        base_b = 8'h78;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_valid("ign_latency", 6);
        check_pair("ign", ea, eb);
        handshake_to_idle("ign");
        repeat (3) @(posedge clk);
        #1;
        check("ign_still_idle", busy, 1'b0);
        check("ign_reads", reads_seen - r0, 8);

        // Reset asserted at k=5 of FETCH.
        @(posedge clk);
        #1;
        issue(8'h90, 8'h98, pair(8'h90), pair(8'h98));
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_busy_before", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_mem_re", mem_re, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ops_valid", ops_valid, 1'b0);
        check("mid_rst_op_a", op_a, 64'h0);
        check("mid_rst_op_b", op_b, 64'h0);
        check("mid_rst_load_count", load_count, 16'h0);
        exp_addr_q.delete();
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh loads after reset; three handshakes for the perf counter.
        for (int v = 0; v < 3; v++) run_vec(v);
        check("final_load_count", load_count, PERF_EN ? 16'd3 : 16'd0);
        check("final_addr_queue_empty", exp_addr_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
